seven_seg_scan_drv: RTL and testbench

- Physical-side consumer of the 32-bit display word produced by the GPIO 7-segment register block.
- Latches the word on a load strobe and applies it only at a frame boundary, so the display never shows half of an old word and half of a new one.
- Time-multiplexes eight hex digits onto a common-anode display with active-low anode and segment outputs.
- Handles per-digit decimal points, per-digit blanking and a ghost-suppression dead time between digits.

---
 rtl/seven_seg_scan_drv.sv | 163 ++++++++++++++++
 tb/tb_seven_seg_scan_drv.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_drv.sv
// ============================================================================
// Module   : seven_seg_scan_drv
// Purpose  : Scans a 32-bit hex display word onto an 8-digit common-anode
//            7-segment display. A new word is captured on a load strobe
//            but is only applied at a frame boundary, so one frame never
//            mixes digits from an old word and a new word. The first
//            GHOST_CYC cycles of every digit slot switch all anodes off to
//            suppress ghosting between digits.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            disp_num[31:0]   - display word, nibble i -> digit i (0 = right)
//            load             - one-cycle strobe, captures disp_num
//            point[7:0]       - per-digit decimal point enable (live)
//            blank[7:0]       - per-digit blank (live)
//            AN[7:0]          - anode enables, active-low (registered)
//            SEGMENT[7:0]     - {dp,g,f,e,d,c,b,a}, active-low (registered)
//            scan_idx[2:0]    - digit slot currently being scanned
//            frame_done       - one-cycle pulse after the digit 7 -> 0 wrap
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scan_drv #(
  parameter int DIV_MAX   = 100000,
  parameter int GHOST_CYC = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_num,
  input  logic        load,
  input  logic [7:0]  point,
  input  logic [7:0]  blank,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic [2:0]  scan_idx,
  output logic        frame_done
);

  localparam int            CW         = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [CW-1:0] C_DIV_LAST = CW'(DIV_MAX - 1);

  // Hex digit -> active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CW-1:0] div_cnt_q,    div_cnt_d;
  logic [2:0]    scan_idx_q,   scan_idx_d;
  logic [31:0]   shadow_q,     shadow_d;
  logic [31:0]   pend_data_q,  pend_data_d;
  logic          pending_q,    pending_d;
  logic [7:0]    an_q,         an_d;
  logic [7:0]    seg_q,        seg_d;
  logic          frame_done_q, frame_done_d;

  logic          w_tick;
  logic          w_boundary;
  logic          w_ghost;
  logic [3:0]    w_nib;

  assign w_tick     = (div_cnt_q == C_DIV_LAST);
  assign w_boundary = w_tick && (scan_idx_q == 3'd7);
  assign w_nib      = shadow_q[{scan_idx_q, 2'b00} +: 4];

  // Dead-time window at the start of each slot; a zero-length window is
  // built as a constant so the comparison never degenerates to "< 0".
  generate
    if (GHOST_CYC > 0) begin : g_ghost
      assign w_ghost = (div_cnt_q < CW'(GHOST_CYC));
    end else begin : g_no_ghost
      assign w_ghost = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    div_cnt_d    = w_tick ? '0 : div_cnt_q + 1'b1;
    scan_idx_d   = w_tick ? scan_idx_q + 3'd1 : scan_idx_q;
    shadow_d     = shadow_q;
    pend_data_d  = pend_data_q;
    pending_d    = pending_q;
    frame_done_d = w_boundary;

    if (w_boundary) begin
      // A load coinciding with the boundary is the newest word, so it goes
      // straight to the shadow and leaves nothing pending.
      if (load) begin
        shadow_d    = disp_num;
        pend_data_d = disp_num;
      end else if (pending_q) begin
        shadow_d    = pend_data_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pend_data_d = disp_num;
      pending_d   = 1'b1;
    end

    // Outputs reflect the current slot/phase/shadow one cycle later.
    if (w_ghost || blank[scan_idx_q]) begin
      an_d = 8'hFF;
    end else begin
      an_d = ~(8'b1 << scan_idx_q);
    end
    seg_d = {~point[scan_idx_q], hex_to_seg(w_nib)};
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      scan_idx_q   <= 3'd0;
      shadow_q     <= 32'h0;
      pend_data_q  <= 32'h0;
      pending_q    <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      scan_idx_q   <= scan_idx_d;
      shadow_q     <= shadow_d;
      pend_data_q  <= pend_data_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign AN         = an_q;
  assign SEGMENT    = seg_q;
  assign scan_idx   = scan_idx_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_drv.sv
// ============================================================================
// Module   : tb_seven_seg_scan_drv
// Purpose  : Self-checking bench for seven_seg_scan_drv. A scripted opening
//            (loads, collisions, boundary load, point/blank, mid-frame reset)
//            is followed by randomized stimulus; every cycle the outputs are
//            compared with a cycle-count based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scan_drv;

  localparam int DIV   = 4;
  localparam int GH    = 1;
  localparam int FRAME = 8 * DIV;
  localparam int NCYC  = 3500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] disp_num = 32'h0;
  logic        load = 1'b0;
  logic [7:0]  point = 8'h0;
  logic [7:0]  blank = 8'h0;
  logic [7:0]  AN;
  logic [7:0]  SEGMENT;
  logic [2:0]  scan_idx;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scan_drv #(
    .DIV_MAX   (DIV),
    .GHOST_CYC (GH)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .disp_num   (disp_num),
    .load       (load),
    .point      (point),
    .blank      (blank),
    .AN         (AN),
    .SEGMENT    (SEGMENT),
    .scan_idx   (scan_idx),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: n counts clock edges since reset released; slot and
  // phase follow directly from it by division.
  logic [6:0]  hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                7'h46, 7'h21, 7'h06, 7'h0E};
  int          m_n       = 0;
  logic [31:0] m_shadow  = 32'h0;
  logic [31:0] m_pend    = 32'h0;
  bit          m_pending = 1'b0;
  logic [7:0]  e_an, e_seg;
  logic        e_fd;
  logic [2:0]  e_idx;

  initial begin
    int   rst_hold;
    int   epoch;
    bit   prev_rst;
    bit   have_exp;
    int   idx;
    int   ph;
    bit   bnd;
    logic [3:0] nib;
    rst_hold = 3;
    epoch    = 0;
    prev_rst = 1'b0;
    have_exp = 1'b0;

    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);

      // ---------------- compare ----------------
      if (have_exp) begin
        check_val("an",  32'(AN),         32'(e_an));
        check_val("seg", 32'(SEGMENT),    32'(e_seg));
        check_val("idx", 32'(scan_idx),   32'(e_idx));
        check_val("fd",  32'(frame_done), 32'(e_fd));
        if (epoch == 1) begin
          case (m_n)
            1:   begin check_val("first_an", 32'(AN), 32'hFF);
                       check_val("first_seg", 32'(SEGMENT), 32'hC0); end
            22:  begin check_val("tear_seg", 32'(SEGMENT), 32'hC0);
                       check_val("tear_an", 32'(AN), 32'hDF); end
            32:  check_val("fd_first", 32'(frame_done), 32'h1);
            34:  begin check_val("ones_seg", 32'(SEGMENT), 32'hF9);
                       check_val("ones_an", 32'(AN), 32'hFE); end
            66:  check_val("last_wins", 32'(SEGMENT), 32'hA4);
            98:  check_val("bnd_load", 32'(SEGMENT), 32'hB0);
            129: check_val("ghost_an", 32'(AN), 32'hFF);
            130: begin check_val("d0_seg", 32'(SEGMENT), 32'h8E);
                       check_val("d0_an", 32'(AN), 32'hFE); end
            158: begin check_val("d7_seg", 32'(SEGMENT), 32'h80);
                       check_val("d7_an", 32'(AN), 32'h7F); end
            162: begin check_val("dp_seg", 32'(SEGMENT), 32'h0E);
                       check_val("dp_an", 32'(AN), 32'hFE); end
            190: check_val("blank_an1", 32'(AN), 32'hFF);
            192: check_val("blank_an2", 32'(AN), 32'hFF);
            194: check_val("dp_off_seg", 32'(SEGMENT), 32'h8E);
            default: ;
          endcase
        end else if (epoch == 2) begin
          case (m_n)
            0:  if (rst) begin
                  check_val("rst_an", 32'(AN), 32'hFF);
                  check_val("rst_seg", 32'(SEGMENT), 32'hFF);
                end
            1:  check_val("post_rst_seg", 32'(SEGMENT), 32'hC0);
            34: begin check_val("discard_d0", 32'(SEGMENT), 32'hC0);
                      check_val("discard_an0", 32'(AN), 32'hFE); end
            62: begin check_val("discard_d7", 32'(SEGMENT), 32'hC0);
                      check_val("discard_an7", 32'(AN), 32'h7F); end
            default: ;
          endcase
        end
      end

      // ---------------- drive ----------------
      load = 1'b0;
      if (rst_hold > 0) begin
        rst = 1'b1;
        rst_hold--;
      end else begin
        rst = 1'b0;
      end

      if (!rst) begin
        if (epoch == 1) begin
          case (m_n)
            10:  begin load = 1'b1; disp_num = 32'h11111111; end
            40:  begin load = 1'b1; disp_num = 32'h00000001; end
            45:  begin load = 1'b1; disp_num = 32'h00000002; end
            95:  begin load = 1'b1; disp_num = 32'h00000003; end
            100: begin load = 1'b1; disp_num = 32'h89ABCDEF; end
            160: begin point = 8'h01; blank = 8'h80; end
            192: begin point = 8'h00; blank = 8'h00; end
            200: begin load = 1'b1; disp_num = 32'h55555555; end
            213: begin rst = 1'b1; rst_hold = 1; end
            default: ;
          endcase
        end else if (epoch >= 3 || (epoch == 2 && m_n >= 2 * FRAME)) begin
          bnd      = ((m_n % FRAME) == FRAME - 1);
          disp_num = $urandom();
          load     = bnd ? ($urandom_range(0, 3) == 0)
                         : ($urandom_range(0, 15) == 0);
          if ($urandom_range(0, 49) == 0) point = 8'($urandom());
          if ($urandom_range(0, 49) == 0) blank = 8'($urandom());
          if ($urandom_range(0, 499) == 0) begin
            rst      = 1'b1;
            rst_hold = $urandom_range(0, 2);
          end
        end
      end

      if (rst && !prev_rst) epoch++;
      prev_rst = rst;

      // ---------------- model step (effect of the coming edge) ----------------
      if (rst) begin
        m_n       = 0;
        m_shadow  = 32'h0;
        m_pend    = 32'h0;
        m_pending = 1'b0;
        e_an      = 8'hFF;
        e_seg     = 8'hFF;
        e_fd      = 1'b0;
        e_idx     = 3'd0;
      end else begin
        idx   = (m_n / DIV) % 8;
        ph    = m_n % DIV;
        nib   = 4'(m_shadow >> (4 * idx));
        e_an  = (ph < GH || blank[idx]) ? 8'hFF : ~(8'b1 << idx);
        e_seg = {~point[idx], hex_tbl[nib]};
        bnd   = ((m_n % FRAME) == FRAME - 1);
        if (bnd) begin
          if (load)           m_shadow = disp_num;
          else if (m_pending) m_shadow = m_pend;
          m_pending = 1'b0;
        end else if (load) begin
          m_pend    = disp_num;
          m_pending = 1'b1;
        end
        m_n++;
        e_fd  = bnd;
        e_idx = 3'((m_n / DIV) % 8);
      end
      have_exp = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
